// File: rtl/ps_packet_arbiter.sv
// Round-robin packet-level arbiter: zero-latency mux of COUNT PacketStream sources onto
// one sink, with the grant held from a packet's first offered word until its eop is accepted.
//  state    | meaning
//  ST_OPEN  | no grant held; rotating-priority search starting at ptr_reg
//  ST_LOCK  | grant_reg owns the sink until its eop word is accepted
module ps_packet_arbiter #(
  parameter int DWIDTH = 32,
  parameter int MWIDTH = 2,
  parameter int COUNT  = 4,
  localparam int SW    = $clog2(COUNT)
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [COUNT-1:0]         i_en,
  input  logic [COUNT*DWIDTH-1:0]  i_dat,
  input  logic [COUNT*MWIDTH-1:0]  i_mty,
  input  logic [COUNT-1:0]         i_val,
  input  logic [COUNT-1:0]         i_eop,
  output logic [COUNT-1:0]         i_rdy,
  output logic [DWIDTH-1:0]        o_dat,
  output logic [MWIDTH-1:0]        o_mty,
  output logic                     o_val,
  output logic                     o_eop,
  input  logic                     o_rdy,
  output logic [SW-1:0]            o_sel,
  output logic                     o_busy
);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t            state_reg, state_nxt;
  logic [SW-1:0]     grant_reg, grant_nxt;
  logic [SW-1:0]     ptr_reg, ptr_nxt;
  logic [SW-1:0]     sel, sel_inc;
  logic [SW:0]       cand;
  logic              offer;
  logic              locked;
  logic [DWIDTH-1:0] dat_arr [COUNT];
  logic [MWIDTH-1:0] mty_arr [COUNT];

  assign locked = (state_reg == ST_LOCK);

  for (genvar k = 0; k < COUNT; k++) begin : g_req
    assign dat_arr[k] = i_dat[k*DWIDTH +: DWIDTH];
    assign mty_arr[k] = i_mty[k*MWIDTH +: MWIDTH];
    assign i_rdy[k]   = ~reset & o_rdy & (sel == SW'(k)) & (locked | (i_val[k] & i_en[k]));
  end

  // Rotating-priority search; the candidate index wraps at COUNT, not at 2**SW.
  always_comb begin
    sel   = ptr_reg;
    offer = 1'b0;
    cand  = '0;
    if (locked) begin
      sel   = grant_reg;
      offer = i_val[grant_reg];
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        cand = {1'b0, ptr_reg} + (SW+1)'(i);
        if (cand >= (SW+1)'(COUNT)) cand = cand - (SW+1)'(COUNT);
        if (!offer && i_val[cand[SW-1:0]] && i_en[cand[SW-1:0]]) begin
          offer = 1'b1;
          sel   = cand[SW-1:0];
        end
      end
    end
  end

  assign sel_inc = (sel == SW'(COUNT-1)) ? '0 : sel + SW'(1);

  assign o_val  = ~reset & offer;
  assign o_sel  = reset ? '0 : sel;
  assign o_dat  = dat_arr[sel];
  assign o_mty  = mty_arr[sel];
  assign o_eop  = i_eop[sel];
  assign o_busy = locked;

  // Lock even on a stalled offer so the presented word cannot change under o_rdy=0.
  always_comb begin
    state_nxt = state_reg;
    grant_nxt = grant_reg;
    ptr_nxt   = ptr_reg;
    if (o_val && o_rdy && o_eop) begin
      state_nxt = ST_OPEN;
      ptr_nxt   = sel_inc;
    end else if (o_val) begin
      state_nxt = ST_LOCK;
      grant_nxt = sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_OPEN;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_nxt;
      grant_reg <= grant_nxt;
      ptr_reg   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_ps_packet_arbiter.sv
// Self-checking bench for ps_packet_arbiter: directed packet sequences, a constant vector
// table, and randomized traffic against a rule-level round-robin reference model.
module tb_ps_packet_arbiter;
  localparam int DW = 32;
  localparam int MW = 2;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    i_en, i_val, i_eop, i_rdy;
  logic [N*DW-1:0] i_dat;
  logic [N*MW-1:0] i_mty;
  logic [DW-1:0]   o_dat;
  logic [MW-1:0]   o_mty;
  logic            o_val, o_eop, o_rdy, o_busy;
  logic [SW-1:0]   o_sel;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: plain integers
  bit m_lock;
  int m_grant, m_ptr;
  int e_sel;
  bit e_val, e_eop;
  logic [N-1:0] acc;

  // packet sources used by the directed tests
  bit auto_src;
  int src_len [N];
  int src_left[N];
  int src_word[N];
  int src_pkt [N];
  int src_mty [N];

  always #5 clk = ~clk;

  ps_packet_arbiter #(.DWIDTH(DW), .MWIDTH(MW), .COUNT(N)) dut (
    .reset(reset), .clk(clk), .i_en(i_en), .i_dat(i_dat), .i_mty(i_mty),
    .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy), .o_dat(o_dat), .o_mty(o_mty),
    .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy), .o_sel(o_sel), .o_busy(o_busy)
  );

  task automatic hchk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      src_len[k] = 1; src_left[k] = 0; src_word[k] = 0; src_pkt[k] = 0; src_mty[k] = k;
    end
  endtask

  task automatic apply_src();
    for (int k = 0; k < N; k++) begin
      i_val[k] = (src_left[k] > 0);
      i_eop[k] = (src_word[k] == src_len[k] - 1);
      i_dat[k*DW +: DW] = {8'(k), 8'(src_pkt[k]), 16'(src_word[k])};
      i_mty[k*MW +: MW] = MW'(src_mty[k]);
    end
  endtask

  // Compare every output against the round-robin rules for the current inputs.
  task automatic check(input string name);
    int sel;
    bit val, owner, ok;
    logic [N-1:0] erdy;
    logic [DW-1:0] edat;
    logic [MW-1:0] emty;
    bit eeop;
    if (reset) begin
      m_lock = 0; m_grant = 0; m_ptr = 0;
      ok = (o_val === 1'b0) && (i_rdy === '0) && (o_busy === 1'b0) && (o_sel === '0);
      e_val = 0; e_eop = 0; e_sel = 0; acc = '0;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s(reset): val=%b rdy=%b busy=%b sel=%0d, required 0/0/0/0",
                 name, o_val, i_rdy, o_busy, o_sel);
      end
      return;
    end
    owner = 0; val = 0; sel = m_ptr;
    if (m_lock) begin
      sel = m_grant; owner = 1; val = i_val[sel];
    end else begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (!owner && i_val[k] && i_en[k]) begin owner = 1; val = 1; sel = k; end
      end
    end
    erdy = '0;
    if (owner) erdy[sel] = o_rdy;
    edat = i_dat[sel*DW +: DW];
    emty = i_mty[sel*MW +: MW];
    eeop = i_eop[sel];
    ok = (o_val === val) && (o_sel === sel[SW-1:0]) && (o_busy === m_lock) &&
         (i_rdy === erdy) && (o_dat === edat) && (o_mty === emty) && (o_eop === eeop);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got val=%b sel=%0d busy=%b rdy=%b dat=%h mty=%0d eop=%b; required val=%b sel=%0d busy=%b rdy=%b dat=%h mty=%0d eop=%b",
               name, o_val, o_sel, o_busy, i_rdy, o_dat, o_mty, o_eop,
               val, sel, m_lock, erdy, edat, emty, eeop);
    end
    e_sel = sel; e_val = val; e_eop = eeop; acc = i_val & erdy;
  endtask

  task automatic pre(input string name);
    if (auto_src) apply_src();
    #1;
    check(name);
  endtask

  task automatic post();
    @(posedge clk);
    if (reset) begin
      m_lock = 0; m_grant = 0; m_ptr = 0;
    end else if (e_val && o_rdy && e_eop) begin
      m_lock = 0; m_ptr = (e_sel + 1) % N;
    end else if (e_val) begin
      m_lock = 1; m_grant = e_sel;
    end
    if (auto_src && !reset) begin
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          if (src_word[k] == src_len[k] - 1) begin
            src_word[k] = 0; src_pkt[k]++; src_left[k]--;
          end else src_word[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_src();
    pre("rst_a"); post();
    pre("rst_b"); post();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] en, val, eop;
    logic       rdy;
    logic       ev;
    int         esel;
    logic       ebusy;
    logic [3:0] erdy;
  } vec_t;
  vec_t tbl[12];

  int q_sel[$];
  int q_eop[$];
  logic [DW-1:0] held;

  initial begin
    tbl[0]  = '{4'b1011, 4'b1111, 4'b0000, 1'b1, 1'b1, 0, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1011, 4'b1111, 4'b0001, 1'b1, 1'b1, 0, 1'b1, 4'b0001};
    tbl[2]  = '{4'b1011, 4'b1111, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0010};
    tbl[3]  = '{4'b1001, 4'b1111, 4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010};
    tbl[4]  = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[5]  = '{4'b1001, 4'b1111, 4'b1000, 1'b1, 1'b1, 3, 1'b1, 4'b1000};
    tbl[6]  = '{4'b1001, 4'b1111, 4'b0001, 1'b1, 1'b1, 0, 1'b0, 4'b0001};
    tbl[7]  = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[8]  = '{4'b1001, 4'b1111, 4'b0000, 1'b0, 1'b1, 3, 1'b1, 4'b0000};
    tbl[9]  = '{4'b1001, 4'b0111, 4'b0000, 1'b1, 1'b0, 3, 1'b1, 4'b1000};
    tbl[10] = '{4'b1001, 4'b1111, 4'b1000, 1'b1, 1'b1, 3, 1'b1, 4'b1000};
    tbl[11] = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000};

    auto_src = 0;
    clear_src();
    reset = 1'b1; i_en = 4'hF; i_val = 4'hF; i_eop = '0; o_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin
      i_dat[k*DW +: DW] = 32'hA5A5_0000 | k;
      i_mty[k*MW +: MW] = MW'(k);
    end
    @(negedge clk);

    // reset with every requester valid, then release
    pre("t1_reset");
    hchk("t1_val_in_reset", {o_val, i_rdy}, 0);
    post();
    reset = 1'b0;
    pre("t1_release");
    hchk("t1_sel_after_release", o_sel, 0);
    post();

    // four requesters, 3-word packets, sink always ready
    auto_src = 1;
    do_reset();
    for (int k = 0; k < N; k++) begin src_len[k] = 3; src_left[k] = 1000; end
    for (int c = 0; c < 15; c++) begin
      pre("t2");
      if (o_val && o_rdy) begin q_sel.push_back(o_sel); q_eop.push_back(o_eop); end
      post();
    end
    hchk("t2_words_moved", q_sel.size(), 15);
    for (int w = 0; w < 15; w++) begin
      int got;
      got = (w < q_sel.size()) ? q_sel[w] * 2 + q_eop[w] : -1;
      hchk("t2_word_sel_eop", got, ((w / 3) % 4) * 2 + ((w % 3) == 2 ? 1 : 0));
    end

    // stalled 4-word packet from req 1; req 2 arrives mid-packet
    do_reset();
    src_len[1] = 4; src_left[1] = 1;
    for (int c = 0; c < 7; c++) begin
      o_rdy = (c % 2 == 0);
      if (c == 2) begin src_len[2] = 2; src_left[2] = 1; end
      pre("t3");
      hchk("t3_sel_held", {o_sel, o_val}, {2'd1, 1'b1});
      if (c > 0 && (c % 2 == 0)) hchk("t3_dat_stable", o_dat, held);
      held = o_dat;
      post();
    end
    o_rdy = 1'b1;
    pre("t3_next");
    hchk("t3_next_sel", {o_sel, o_val, o_busy}, {2'd2, 1'b1, 1'b0});
    post();

    // only req 3, single-word packets with mty=3
    do_reset();
    src_len[3] = 1; src_left[3] = 1000; src_mty[3] = 3;
    for (int c = 0; c < 6; c++) begin
      pre("t4");
      hchk("t4_fields", {o_val, o_eop, o_mty, o_busy, o_sel}, {1'b1, 1'b1, 2'd3, 1'b0, 2'd3});
      post();
    end
    for (int k = 0; k < N; k++) begin src_len[k] = 1; src_left[k] = 1; end
    pre("t4_wrap");
    hchk("t4_ptr_wrapped", o_sel, 0);
    post();

    // reset asserted during word 2 of a req 2 packet
    do_reset();
    src_len[2] = 4; src_left[2] = 1;
    pre("t6_w1"); post();
    reset = 1'b1;
    clear_src();
    for (int k = 0; k < N; k++) begin src_len[k] = 2; src_left[k] = 1; end
    pre("t6_in_reset");
    post();
    reset = 1'b0;
    pre("t6_restart");
    hchk("t6_restart", {o_sel, o_busy, o_val}, {2'd0, 1'b0, 1'b1});
    post();

    // enable masking, skip, stall and mid-packet valid drop from the vector table
    auto_src = 0;
    do_reset();
    for (int k = 0; k < N; k++) begin
      i_dat[k*DW +: DW] = 32'hC0DE_0000 | k;
      i_mty[k*MW +: MW] = MW'(k);
    end
    for (int r = 0; r < 12; r++) begin
      i_en = tbl[r].en; i_val = tbl[r].val; i_eop = tbl[r].eop; o_rdy = tbl[r].rdy;
      pre("t5_model");
      n_vec++;
      if (o_val !== tbl[r].ev || o_sel !== tbl[r].esel[SW-1:0] || o_busy !== tbl[r].ebusy ||
          i_rdy !== tbl[r].erdy || o_dat !== (32'hC0DE_0000 | tbl[r].esel) ||
          o_eop !== tbl[r].eop[tbl[r].esel] || o_mty !== tbl[r].esel[MW-1:0]) begin
        n_err++;
        $display("FAIL t5_row%0d: got val=%b sel=%0d busy=%b rdy=%b dat=%h; required val=%b sel=%0d busy=%b rdy=%b",
                 r, o_val, o_sel, o_busy, i_rdy, o_dat, tbl[r].ev, tbl[r].esel, tbl[r].ebusy, tbl[r].erdy);
      end
      post();
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(63) == 0);
      if (c % 16 == 0) i_en = 4'($urandom);
      i_val = 4'($urandom);
      i_eop = 4'($urandom);
      o_rdy = ($urandom_range(3) != 0);
      for (int k = 0; k < N; k++) begin
        i_dat[k*DW +: DW] = $urandom;
        i_mty[k*MW +: MW] = MW'($urandom);
      end
      pre("rand");
      post();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
